// File: rtl/hs_pkg.sv
// Shared types and defaults for the hs_skid_slice stream pipeline slice.
package hs_pkg;

   localparam int HS_DATA_W = 32;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      BUSY  = 2'b01,
      FULL  = 2'b10
   } hs_state_t;

endpackage

// File: rtl/hs_xfer_counter.sv
// Wrapping transfer counter: increments on en_i, cleared synchronously by clear_i.
// Latency: count reflects an enable one cycle later. No backpressure.
module hs_xfer_counter
   import hs_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             clear_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (clear_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hs_skid_slice.sv
// Registered valid/ready slice with one-entry skid buffer; 1-cycle latency, s_ready registered.
// Optional accepted-output counter on xfer_cnt when HS_XFER_CNT_EN is defined.
module hs_skid_slice
   import hs_pkg::*;
#(
   parameter int DATA_W = HS_DATA_W
`ifdef HS_XFER_CNT_EN
   ,
   parameter int CNT_W  = 32
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready
`ifdef HS_XFER_CNT_EN
   ,
   output logic [CNT_W-1:0]  xfer_cnt
`endif
);

   hs_state_t         state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              s_ready_q, m_valid_q;
   logic              s_xfer, m_xfer;

   // s_ready_q gates acceptance so nothing lands in the cycle right after reset
   assign s_xfer = s_valid & s_ready_q;
   assign m_xfer = m_valid_q & m_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (s_xfer) begin
               main_d  = s_data;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (s_xfer && m_ready) begin
               main_d = s_data;
            end else if (s_xfer) begin
               skid_d  = s_data;
               state_d = FULL;
            end else if (m_ready) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (m_ready) begin
               main_d  = skid_q;
               state_d = BUSY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         main_q    <= main_d;
         skid_q    <= skid_d;
         s_ready_q <= (state_d != FULL);
         m_valid_q <= (state_d != EMPTY);
      end
   end

   assign s_ready = s_ready_q;
   assign m_valid = m_valid_q;
   assign m_data  = main_q;

`ifdef HS_XFER_CNT_EN
   hs_xfer_counter #(
      .CNT_W (CNT_W)
   ) u_xfer_counter (
      .clk     (clk),
      .clear_i (rst),
      .en_i    (m_xfer),
      .cnt_o   (xfer_cnt)
   );
`endif

endmodule
